// File: rtl/input_manager_multi.sv
// Turns per-channel raw key levels into one-cycle command pulses with one-shot, DAS or
// fast-repeat behaviour, an opposing-pair resolver (last pressed wins) and an enable gate.
module input_manager_multi #(
  parameter int unsigned         NUM_CH     = 6,
  parameter logic [2*NUM_CH-1:0] MODES      = 12'h025,
  parameter int unsigned         CNT_W      = 6,
  parameter int unsigned         DAS_DELAY  = 16,
  parameter int unsigned         DAS_SPEED  = 6,
  parameter int unsigned         SOFT_SPEED = 2,
  parameter bit                  OPP_EN     = 1'b1,
  parameter int unsigned         OPP_A      = 0,
  parameter int unsigned         OPP_B      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tick_game,
  input  logic [NUM_CH-1:0] raw,
  output logic [NUM_CH-1:0] cmd,
  output logic [NUM_CH-1:0] das_charged
);

  typedef enum logic [1:0] {PhIdle, PhDelay, PhRepeat} phase_e;
  typedef enum logic [1:0] {OwnNone, OwnA, OwnB} owner_e;

  localparam logic [CNT_W-1:0] DasDelayC  = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] DasSpeedC  = CNT_W'(DAS_SPEED);
  localparam logic [CNT_W-1:0] SoftSpeedC = CNT_W'(SOFT_SPEED);

  logic [NUM_CH-1:0] raw_q, cmd_q, cmd_d, das_q, das_d;
  logic [NUM_CH-1:0] press, rearm, allowed;
  phase_e            phase_q [NUM_CH];
  phase_e            phase_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  owner_e            owner_q, owner_d;

  assign press = raw & ~raw_q;

  // Ownership follows the latest press; releasing the owner hands over to a still-held partner,
  // which then re-arms exactly like a fresh press.
  always_comb begin
    owner_d = owner_q;
    rearm   = '0;
    if (OPP_EN) begin
      if (press[OPP_A]) begin
        owner_d = OwnA;
      end else if (press[OPP_B]) begin
        owner_d = OwnB;
      end else if (owner_q == OwnA && !raw[OPP_A]) begin
        owner_d      = raw[OPP_B] ? OwnB : OwnNone;
        rearm[OPP_B] = raw[OPP_B];
      end else if (owner_q == OwnB && !raw[OPP_B]) begin
        owner_d      = raw[OPP_A] ? OwnA : OwnNone;
        rearm[OPP_A] = raw[OPP_A];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (OPP_EN && i == OPP_A)      allowed[i] = (owner_d == OwnA);
      else if (OPP_EN && i == OPP_B) allowed[i] = (owner_d == OwnB);
      else                           allowed[i] = 1'b1;
    end
  end

  always_comb begin
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thr;
    mode    = '0;
    cnt_inc = '0;
    thr     = '0;
    cmd_d   = '0;
    das_d   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      mode       = MODES[2*i +: 2];
      cnt_inc    = cnt_q[i] + 1'b1;
      thr        = (mode == 2'd1) ? DasSpeedC : SoftSpeedC;
      phase_d[i] = phase_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!enable || !raw[i] || !allowed[i]) begin
        phase_d[i] = PhIdle;
        cnt_d[i]   = '0;
      end else if (press[i] || rearm[i]) begin
        // A press outranks a coincident tick: the tick is simply not counted.
        cmd_d[i] = 1'b1;
        cnt_d[i] = '0;
        case (mode)
          2'd1:    phase_d[i] = PhDelay;
          2'd2:    phase_d[i] = PhRepeat;
          default: phase_d[i] = PhIdle;
        endcase
      end else if (tick_game) begin
        case (phase_q[i])
          PhDelay: begin
            if (cnt_inc == DasDelayC) begin
              phase_d[i] = PhRepeat;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_inc;
            end
          end
          PhRepeat: begin
            if (cnt_inc == thr) begin
              cmd_d[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_inc;
            end
          end
          default: ;
        endcase
      end
      das_d[i] = (mode == 2'd1) && (phase_d[i] == PhRepeat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q   <= '0;
      cmd_q   <= '0;
      das_q   <= '0;
      owner_q <= OwnNone;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= PhIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      raw_q   <= raw;
      cmd_q   <= cmd_d;
      das_q   <= das_d;
      owner_q <= owner_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign cmd         = cmd_q;
  assign das_charged = das_q;

endmodule
